// File: rtl/packed_network_ctrl.sv
// packed_network_ctrl
// Scheduler and configuration store for a cascade of packed_stage instances.
// Each beat is tagged with a permutation id. The id travels down a delay line
// alongside the beat, so every stage gets that permutation's switch word in the
// cycle the beat reaches it. Configuration writes are accepted only when the
// network is empty. A write request that arrives mid-stream drains the pipeline
// before it commits.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   I_VALID/I_PERM        beat presented on stage 0 with its permutation id
//   I_READY               beat accepted when I_VALID && I_READY
//   CFG_VALID/PERM/STAGE/DATA  configuration write request
//   CFG_READY             write commits when CFG_VALID && CFG_READY
//   SWITCH_SET            registered per-stage switch settings
//   O_VALID/O_PERM        beat (and its id) leaving the last stage
//   BUSY                  one or more beats in flight
module packed_network_ctrl #(
    parameter int unsigned PORT_NUM   = 32,
    parameter int unsigned SWITCH_NUM = PORT_NUM / 2,
    parameter int unsigned STAGE_NUM  = 9,
    parameter int unsigned STAGE_LAT  = 2,
    parameter int unsigned NUM_PERM   = 4,
    parameter int unsigned PERM_W     = $clog2(NUM_PERM)
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  I_VALID,
    input  logic [PERM_W-1:0]                     I_PERM,
    output logic                                  I_READY,
    input  logic                                  CFG_VALID,
    input  logic [PERM_W-1:0]                     CFG_PERM,
    input  logic [$clog2(STAGE_NUM)-1:0]          CFG_STAGE,
    input  logic [SWITCH_NUM-1:0]                 CFG_DATA,
    output logic                                  CFG_READY,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  SWITCH_SET,
    output logic                                  O_VALID,
    output logic [PERM_W-1:0]                     O_PERM,
    output logic                                  BUSY
);

    localparam int unsigned DEPTH   = STAGE_NUM * STAGE_LAT;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned STAGE_W = $clog2(STAGE_NUM);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_NUM - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                                     r_state, w_state_d;
    logic [CNT_W-1:0]                           r_cnt, w_cnt_d;
    logic [DEPTH-2:0]                           r_dly_vld;
    logic [DEPTH-2:0][PERM_W-1:0]               r_dly_perm;
    logic [DEPTH-1:0]                           w_tap_vld;
    logic [DEPTH-1:0][PERM_W-1:0]               w_tap_perm;
    logic [NUM_PERM-1:0][STAGE_NUM-1:0][SWITCH_NUM-1:0] r_cfg;
    logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]       r_sw, w_sw_d;
    logic                                       r_o_valid;
    logic [PERM_W-1:0]                          r_o_perm;
    logic                                       w_i_ready, w_cfg_ready;
    logic                                       w_accept, w_cfg_commit;

    assign w_accept     = I_VALID && w_i_ready;
    assign w_cfg_commit = CFG_VALID && w_cfg_ready;

    // Tap k is the beat accepted k edges ago; tap 0 is the beat being accepted
    // now, so stage 0 is loaded on the same edge as the accept.
    assign w_tap_vld  = {r_dly_vld, w_accept};
    assign w_tap_perm = {r_dly_perm, (w_accept ? I_PERM : PERM_W'(0))};

    // Ready outputs are forced low while reset is held.
    always_comb begin
        w_i_ready   = 1'b0;
        w_cfg_ready = 1'b0;
        case (r_state)
            StIdle: begin
                w_i_ready   = !CFG_VALID;
                w_cfg_ready = 1'b1;
            end
            StRun: begin
                w_i_ready = 1'b1;
            end
            default: begin
                w_i_ready   = 1'b0;
                w_cfg_ready = 1'b0;
            end
        endcase
        if (RST) begin
            w_i_ready   = 1'b0;
            w_cfg_ready = 1'b0;
        end
    end

    // Accept and emit in the same cycle leave the count unchanged.
    always_comb begin
        w_cnt_d = r_cnt;
        case ({w_accept, r_o_valid})
            2'b10:   w_cnt_d = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt - CNT_W'(1);
            default: w_cnt_d = r_cnt;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StRun;
            end
            StRun: begin
                // A zero next count implies no accept this cycle.
                if (w_cnt_d == '0)   w_state_d = StIdle;
                else if (CFG_VALID)  w_state_d = StDrain;
            end
            StDrain: begin
                if (w_cnt_d == '0) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_sw_d = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (w_tap_vld[s*STAGE_LAT]) begin
                w_sw_d[s] = r_cfg[w_tap_perm[s*STAGE_LAT]][s];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_dly_vld  <= '0;
            r_dly_perm <= '0;
            r_sw       <= '0;
            r_o_valid  <= 1'b0;
            r_o_perm   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_dly_vld  <= w_tap_vld[DEPTH-2:0];
            r_dly_perm <= w_tap_perm[DEPTH-2:0];
            r_sw       <= w_sw_d;
            r_o_valid  <= w_tap_vld[DEPTH-1];
            r_o_perm   <= w_tap_perm[DEPTH-1];
        end
    end

    // Out-of-range stage writes complete the handshake but touch nothing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cfg <= '0;
        end else if (w_cfg_commit && (CFG_STAGE <= STAGE_LAST)) begin
            r_cfg[CFG_PERM][CFG_STAGE] <= CFG_DATA;
        end
    end

    assign I_READY    = w_i_ready;
    assign CFG_READY  = w_cfg_ready;
    assign SWITCH_SET = r_sw;
    assign O_VALID    = r_o_valid;
    assign O_PERM     = r_o_perm;
    assign BUSY       = (r_cnt != '0);

endmodule

// File: tb/tb_packed_network_ctrl.sv
// tb_packed_network_ctrl
// Directed bench for packed_network_ctrl with default parameters.
// hist[] records which id the bench expects to be accepted at each edge. After
// every edge, the expected SWITCH_SET, O_VALID, O_PERM and BUSY values are
// derived from hist[] and the bench copy of the configuration.
module tb_packed_network_ctrl;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              I_VALID = 1'b0;
    logic [1:0]        I_PERM = '0;
    logic              I_READY;
    logic              CFG_VALID = 1'b0;
    logic [1:0]        CFG_PERM = '0;
    logic [3:0]        CFG_STAGE = '0;
    logic [15:0]       CFG_DATA = '0;
    logic              CFG_READY;
    logic [0:8][15:0]  SWITCH_SET;
    logic              O_VALID;
    logic [1:0]        O_PERM;
    logic              BUSY;

    packed_network_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_VALID    (I_VALID),
        .I_PERM     (I_PERM),
        .I_READY    (I_READY),
        .CFG_VALID  (CFG_VALID),
        .CFG_PERM   (CFG_PERM),
        .CFG_STAGE  (CFG_STAGE),
        .CFG_DATA   (CFG_DATA),
        .CFG_READY  (CFG_READY),
        .SWITCH_SET (SWITCH_SET),
        .O_VALID    (O_VALID),
        .O_PERM     (O_PERM),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hist [1024];
    logic [15:0] bcfg [4][9];

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [0:8][15:0] esw;
        logic             eov;
        logic [1:0]       eop;
        logic             ebusy;
        int               idx;
        esw = '0;
        for (int s = 0; s < 9; s++) begin
            idx = cyc - 2 * s;
            if (idx >= 0 && hist[idx] >= 0) esw[s] = bcfg[hist[idx]][s];
        end
        idx = cyc - 17;
        eov = 1'b0;
        eop = '0;
        if (idx >= 0 && hist[idx] >= 0) begin
            eov = 1'b1;
            eop = 2'(hist[idx]);
        end
        ebusy = 1'b0;
        for (int e = cyc - 17; e <= cyc; e++) begin
            if (e >= 0 && hist[e] >= 0) ebusy = 1'b1;
        end
        chk("switch_set", SWITCH_SET, esw);
        chk("o_valid", O_VALID, eov);
        chk("o_perm", O_PERM, eop);
        chk("busy", BUSY, ebusy);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic idle(input int n);
        I_VALID = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_beat(input int p, input logic exp_rdy);
        I_VALID = 1'b1;
        I_PERM  = 2'(p);
        #1;
        chk("i_ready", I_READY, exp_rdy);
        if (exp_rdy) hist[cyc+1] = p;
        tick();
    endtask

    // Write while idle: CFG_READY must already be high.
    task automatic cfg_write(input int p, input int s, input logic [15:0] d);
        CFG_VALID = 1'b1;
        CFG_PERM  = 2'(p);
        CFG_STAGE = 4'(s);
        CFG_DATA  = d;
        #1;
        chk("cfg_ready", CFG_READY, 1'b1);
        tick();
        if (s < 9) bcfg[p][s] = d;
        CFG_VALID = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) hist[i] = -1;
        for (int p = 0; p < 4; p++)
            for (int s = 0; s < 9; s++) bcfg[p][s] = '0;
    endtask

    initial begin
        logic [15:0] onehot;
        int          e0;
        clear_model();

        // Reset: readies held low even with a write pending.
        CFG_VALID = 1'b1;
        #1;
        chk("rst_i_ready", I_READY, 1'b0);
        chk("rst_cfg_ready", CFG_READY, 1'b0);
        chk("rst_switch_set", SWITCH_SET, '0);
        chk("rst_o_valid", O_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        tick();
        tick();
        CFG_VALID = 1'b0;
        RST = 1'b0;
        #1;
        chk("rel_i_ready", I_READY, 1'b1);
        chk("rel_cfg_ready", CFG_READY, 1'b1);

        // Single beat through a one-hot configuration.
        for (int s = 0; s < 9; s++) cfg_write(1, s, 16'h0001 << s);
        send_beat(1, 1'b1);
        e0 = cyc;
        I_VALID = 1'b0;
        chk("t1_sw0", SWITCH_SET[0], 16'h0001);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k % 2 == 0 && k <= 16) begin
                onehot = 16'h0001 << (k / 2);
                chk("t1_sw", SWITCH_SET[k/2], onehot);
            end
            if (cyc == e0 + 17) begin
                chk("t1_o_valid", O_VALID, 1'b1);
                chk("t1_o_perm", O_PERM, 2'd1);
            end
        end
        chk("t1_busy_end", BUSY, 1'b0);

        // Distinct patterns for every perm, then a 20-beat stream.
        for (int p = 0; p < 4; p++)
            for (int s = 0; s < 9; s++) cfg_write(p, s, 16'((p + 1) * 4096 + s * 257));
        for (int i = 0; i < 20; i++) send_beat(i % 4, 1'b1);
        idle(20);

        // Write request mid-stream with 6 beats in flight.
        for (int i = 0; i < 6; i++) send_beat(i % 4, 1'b1);
        I_VALID   = 1'b0;
        CFG_VALID = 1'b1;
        CFG_PERM  = 2'd2;
        CFG_STAGE = 4'd0;
        CFG_DATA  = 16'hBEEF;
        #1;
        chk("mid_cfg_ready", CFG_READY, 1'b0);
        chk("mid_i_ready", I_READY, 1'b1);
        tick();
        I_VALID = 1'b1;
        I_PERM  = 2'd2;
        repeat (17) begin
            #1;
            chk("drain_i_ready", I_READY, 1'b0);
            chk("drain_cfg_ready", CFG_READY, 1'b0);
            tick();
        end
        chk("drained_cfg_ready", CFG_READY, 1'b1);
        chk("drained_i_ready", I_READY, 1'b0);
        tick();
        bcfg[2][0] = 16'hBEEF;
        CFG_VALID = 1'b0;
        send_beat(2, 1'b1);
        chk("new_word_used", SWITCH_SET[0], 16'hBEEF);
        idle(20);

        // Config and data together while idle: config wins.
        CFG_VALID = 1'b1;
        CFG_PERM  = 2'd3;
        CFG_STAGE = 4'd1;
        CFG_DATA  = 16'h5A5A;
        I_VALID   = 1'b1;
        I_PERM    = 2'd3;
        #1;
        chk("both_cfg_ready", CFG_READY, 1'b1);
        chk("both_i_ready", I_READY, 1'b0);
        tick();
        bcfg[3][1] = 16'h5A5A;
        CFG_VALID = 1'b0;
        send_beat(3, 1'b1);
        idle(20);

        // Out-of-range stage: handshake only.
        cfg_write(0, 12, 16'hFFFF);
        for (int i = 0; i < 4; i++) send_beat(i, 1'b1);
        idle(20);

        // Reset with 10 beats in flight.
        for (int i = 0; i < 10; i++) send_beat(i % 4, 1'b1);
        I_VALID = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        chk("ar_switch_set", SWITCH_SET, '0);
        chk("ar_o_valid", O_VALID, 1'b0);
        chk("ar_o_perm", O_PERM, 2'd0);
        chk("ar_busy", BUSY, 1'b0);
        chk("ar_i_ready", I_READY, 1'b0);
        chk("ar_cfg_ready", CFG_READY, 1'b0);
        clear_model();
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("ar_rel_i_ready", I_READY, 1'b1);
        chk("ar_rel_cfg_ready", CFG_READY, 1'b1);
        idle(20);
        send_beat(1, 1'b1);
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
